// File: rtl/i2c_pwm_regfile.sv
// rtl/i2c_pwm_regfile.sv - I2C slave duty-register bank for PWM channels; read path under I2C_READBACK_EN
module i2c_pwm_regfile #(
  parameter logic [6:0] I2C_ADDR   = 7'h42,
  parameter int         NUM_REGS   = 8,
  parameter int         FILTER_LEN = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic [8*NUM_REGS-1:0]       values,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_index,
  output logic                        busy
);
  localparam int IW = $clog2(NUM_REGS);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] PTR_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
`ifdef I2C_READBACK_EN
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RACK_WAIT = 4'd8;
`endif

  logic [1:0]            scl_sync_q, sda_sync_q;
  logic [FILTER_LEN-2:0] scl_hist_q, sda_hist_q;
  logic [FILTER_LEN-1:0] scl_win, sda_win;
  logic                  scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;
  logic                  start_det, stop_det, scl_rise, scl_fall;

  logic [3:0]            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            shift_q, shift_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic [8*NUM_REGS-1:0] values_q, values_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [IW-1:0]         wr_index_q, wr_index_d;
  logic [7:0]            byte_in;
  logic                  addr_match;
`ifdef I2C_READBACK_EN
  logic                  rd_q, rd_d;
  logic [6:0]            tx_q, tx_d;
  logic [7:0]            cur_byte;
  assign cur_byte = values_q[{ptr_q, 3'b000} +: 8];
`endif

  // The window is the newest synchronized sample plus the previous FILTER_LEN-1
  assign scl_win = {scl_hist_q, scl_sync_q[1]};
  assign sda_win = {sda_hist_q, sda_sync_q[1]};

  assign start_det  = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop_det   = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
  assign scl_rise   = scl_f_q & ~scl_prev_q;
  assign scl_fall   = ~scl_f_q & scl_prev_q;
  assign byte_in    = {shift_q, sda_f_q};
  assign addr_match = (byte_in[7:1] == I2C_ADDR);

  // Synchronize both pins, accept a level only after FILTER_LEN agreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_hist_q <= scl_win[FILTER_LEN-2:0];
      sda_hist_q <= sda_win[FILTER_LEN-2:0];
      if (&scl_win)       scl_f_q <= 1'b1;
      else if (~|scl_win) scl_f_q <= 1'b0;
      if (&sda_win)       sda_f_q <= 1'b1;
      else if (~|sda_win) sda_f_q <= 1'b0;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  // Protocol FSM: bytes are sampled on scl rise, SDA is only moved after scl fall
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    values_d    = values_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
`ifdef I2C_READBACK_EN
    rd_d        = rd_q;
    tx_d        = tx_q;
`endif
    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ADDR) begin
                state_d = IDLE;
`ifdef I2C_READBACK_EN
                if (addr_match) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rd_d    = byte_in[0];
                end
`else
                if (addr_match && !byte_in[0]) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                end
`endif
              end else if (state_q == PTR) begin
                ptr_d   = byte_in[IW-1:0];
                state_d = PTR_ACK;
              end else begin
                values_d[{ptr_q, 3'b000} +: 8] = byte_in;
                wr_strobe_d = 1'b1;
                wr_index_d  = ptr_q;
                ptr_d       = ptr_q + 1'b1;
                state_d     = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // first fall: pull SDA for the ack bit; second fall: release and move on
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              oe_d      = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = (state_q == ADDR_ACK) ? PTR : WDATA;
`ifdef I2C_READBACK_EN
              if (state_q == ADDR_ACK && rd_q) begin
                state_d = RDATA;
                tx_d    = cur_byte[6:0];
                oe_d    = ~cur_byte[7];
              end
`endif
            end
          end
        end
`ifdef I2C_READBACK_EN
        RDATA: begin
          if (scl_rise) begin
            if (bit_cnt_q == 4'd8) begin
              if (!sda_f_q) begin
                ptr_d     = ptr_q + 1'b1;
                bit_cnt_d = 4'd9;
              end else begin
                state_d = RACK_WAIT;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd9) begin
              tx_d      = cur_byte[6:0];
              oe_d      = ~cur_byte[7];
              bit_cnt_d = 4'd0;
            end else if (bit_cnt_q == 4'd8) begin
              oe_d = 1'b0;
            end else begin
              tx_d = {tx_q[5:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
        end
        RACK_WAIT: begin
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Register FSM state, duty bank and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      values_q    <= '0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
`ifdef I2C_READBACK_EN
      rd_q        <= 1'b0;
      tx_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      values_q    <= values_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
`ifdef I2C_READBACK_EN
      rd_q        <= rd_d;
      tx_q        <= tx_d;
`endif
    end
  end

  assign sda_oe    = oe_q;
  assign values    = values_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_pwm_regfile.sv
// tb/tb_i2c_pwm_regfile.sv - directed I2C master with byte-level register model
module tb_i2c_pwm_regfile;
  localparam int Q = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe, wr_strobe, busy;
  logic [63:0] values;
  logic [2:0]  wr_index;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mregs [8];
  int         mptr;
  int         mphase;
  logic       mbusy;
  int         exp_strb [$];
  int         got_strb [$];

  assign sda_line = sda_m & ~sda_oe;

  i2c_pwm_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .values    (values),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .busy      (busy)
  );

  always #42 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[8*i +: 8] = mregs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    mptr = 0;
    mphase = 0;
    mbusy = 1'b0;
    exp_strb.delete();
    got_strb.delete();
  endtask

  // byte-level meaning of a completed byte; returns the expected ack bit (0 = ACK)
  task automatic model_byte(input logic [7:0] b, output logic nack);
    nack = 1'b1;
    case (mphase)
      1: begin
        if (b[7:1] == 7'h42 && !b[0]) begin
          nack = 1'b0; mbusy = 1'b1; mphase = 2;
        end
`ifdef I2C_READBACK_EN
        else if (b[7:1] == 7'h42) begin
          nack = 1'b0; mbusy = 1'b1; mphase = 4;
        end
`endif
        else mphase = 0;
      end
      2: begin mptr = int'(b[2:0]); nack = 1'b0; mphase = 3; end
      3: begin
        mregs[mptr] = b;
        exp_strb.push_back(mptr);
        mptr = (mptr + 1) % 8;
        nack = 1'b0;
      end
      default: ;
    endcase
  endtask

  // continuous check of the register bank and busy once the bus has been quiet a while
  int   stable = 0;
  logic last_scl = 1'b1;
  logic last_sda = 1'b1;
  always @(negedge clk) begin
    if (rst) stable = 0;
    else if (scl_m !== last_scl || sda_line !== last_sda) stable = 0;
    else if (stable < 1000) stable++;
    last_scl = scl_m;
    last_sda = sda_line;
    if (!rst && stable >= 10) begin
      chk("values", values, model_flat());
      chk("busy", {63'd0, busy}, {63'd0, mbusy});
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_strobe) got_strb.push_back(int'(wr_index));
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_q();
    if (!scl_m) begin scl_m = 1'b1; wait_q(); end
    sda_m = 1'b0;
    mphase = 1;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    mphase = 0;
    mbusy = 1'b0;
    wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input bit glitch, output logic nack);
    nack = 1'b1;
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i];
      if (glitch && i == 3) begin
        repeat (Q/2) @(posedge clk);
        #1 scl_m = 1'b1;
        @(posedge clk);
        #1 scl_m = 1'b0;
      end
      wait_q();
      scl_m = 1'b1;
      if (n == 8 && i == 0) model_byte(b, nack);
      wait_q();
      wait_q();
      scl_m = 1'b0;
      wait_q();
    end
  endtask

  task automatic write_byte(input string name, input logic [7:0] b, input bit glitch);
    logic exp_nack, got_nack;
    send_bits(b, 8, glitch, exp_nack);
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    got_nack = sda_line;
    wait_q();
    scl_m = 1'b0;
    wait_q();
    chk(name, {63'd0, got_nack}, {63'd0, exp_nack});
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1;
      wait_q();
      scl_m = 1'b1;
      wait_q();
      b[i] = sda_line;
      wait_q();
      scl_m = 1'b0;
      wait_q();
    end
    sda_m = ack_bit;
    wait_q();
    scl_m = 1'b1;
    if (!ack_bit) mptr = (mptr + 1) % 8;
    else mphase = 0;
    wait_q();
    wait_q();
    scl_m = 1'b0;
    wait_q();
    sda_m = 1'b1;
  endtask

  task automatic check_strobes(input string name);
    chk({name, " strobe count"}, 64'(got_strb.size()), 64'(exp_strb.size()));
    for (int i = 0; i < got_strb.size() && i < exp_strb.size(); i++)
      chk({name, " strobe index"}, 64'(got_strb[i]), 64'(exp_strb[i]));
    got_strb.delete();
    exp_strb.delete();
  endtask

  initial begin
    logic [7:0] rd0, rd1;
    logic       dummy;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("reset values", values, 64'd0);
    chk("reset sda_oe", {63'd0, sda_oe}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset wr_strobe", {63'd0, wr_strobe}, 64'd0);
    rst = 1'b0;
    wait_q();

    // single write to reg2
    i2c_start();
    write_byte("t2 addr ack", 8'h84, 1'b0);
    write_byte("t2 ptr ack", 8'h02, 1'b0);
    write_byte("t2 data ack", 8'h28, 1'b0);
    i2c_stop();
    chk("t2 reg2", {56'd0, values[23:16]}, 64'h28);
    chk("t2 one strobe", 64'(got_strb.size()), 64'd1);
    check_strobes("t2");

    // pointer wrap 7 -> 0
    i2c_start();
    write_byte("t3 addr ack", 8'h84, 1'b0);
    write_byte("t3 ptr ack", 8'h07, 1'b0);
    write_byte("t3 d0 ack", 8'hFF, 1'b0);
    write_byte("t3 d1 ack", 8'h11, 1'b0);
    i2c_stop();
    chk("t3 reg7", {56'd0, values[63:56]}, 64'hFF);
    chk("t3 reg0", {56'd0, values[7:0]}, 64'h11);
    chk("t3 two strobes", 64'(got_strb.size()), 64'd2);
    check_strobes("t3");

    // foreign address is not acknowledged
    i2c_start();
    write_byte("t4 addr nack", 8'h86, 1'b0);
    chk("t4 busy", {63'd0, busy}, 64'd0);
    i2c_stop();
    check_strobes("t4");

    // preload reg5/reg6
    i2c_start();
    write_byte("t5 addr ack", 8'h84, 1'b0);
    write_byte("t5 ptr ack", 8'h05, 1'b0);
    write_byte("t5 d0 ack", 8'hA5, 1'b0);
    write_byte("t5 d1 ack", 8'h3C, 1'b0);
    i2c_stop();
    check_strobes("t5");

    // pointer write, repeated START, read
    i2c_start();
    write_byte("t6 addr ack", 8'h84, 1'b0);
    write_byte("t6 ptr ack", 8'h05, 1'b0);
    i2c_start();
    write_byte("t6 raddr", 8'h85, 1'b0);
`ifdef I2C_READBACK_EN
    begin
      logic [7:0] e0, e1;
      e0 = mregs[mptr];
      read_byte(1'b0, rd0);
      e1 = mregs[mptr];
      read_byte(1'b1, rd1);
      chk("t6 rd0 model", {56'd0, rd0}, {56'd0, e0});
      chk("t6 rd1 model", {56'd0, rd1}, {56'd0, e1});
      chk("t6 rd0", {56'd0, rd0}, 64'hA5);
      chk("t6 rd1", {56'd0, rd1}, 64'h3C);
    end
`else
    rd0 = 8'h00;
    rd1 = 8'h00;
    chk("t6 sda released", {63'd0, sda_oe}, 64'd0);
`endif
    i2c_stop();
    check_strobes("t6");

    // scl glitch inside a byte, then a partial byte cut by STOP
    i2c_start();
    write_byte("t7 addr ack", 8'h84, 1'b0);
    write_byte("t7 ptr ack", 8'h03, 1'b0);
    write_byte("t7 data ack", 8'h5A, 1'b1);
    send_bits(8'hB0, 4, 1'b0, dummy);
    i2c_stop();
    chk("t7 reg3", {56'd0, values[31:24]}, 64'h5A);
    chk("t7 one strobe", 64'(got_strb.size()), 64'd1);
    check_strobes("t7");

    // reset while the slave is driving an ack
    i2c_start();
    write_byte("t8 addr ack", 8'h84, 1'b0);
    send_bits(8'h01, 8, 1'b0, dummy);
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    chk("t8 acking", {63'd0, sda_oe}, 64'd1);
    rst = 1'b1;
    #1;
    chk("t8 rst values", values, 64'd0);
    chk("t8 rst sda_oe", {63'd0, sda_oe}, 64'd0);
    chk("t8 rst busy", {63'd0, busy}, 64'd0);
    model_reset();
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_q();
    check_strobes("t8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_pwm_regfile.md
Name: i2c_pwm_regfile

Overview:
- I2C slave with a bank of 8-bit duty registers; directly upstream of the per-channel PWM generators in the LED board top level.
- Oversamples SCL/SDA on the 12 MHz system clock and decodes START, STOP, address, register pointer and data bytes.
- Drives a flat duty-value bus, one byte per PWM channel; each channel consumes its byte as its duty value.
- Open-drain SDA: the top level ties the pin low when sda_oe=1 and leaves it released otherwise.

Parameters:
- I2C_ADDR, 7'h42, 7-bit slave address.
- NUM_REGS, 8, number of duty registers (power of two, 2..16).
- FILTER_LEN, 3, consecutive identical synchronized samples required before a line change is accepted.

Ports:
- clk  input  1  system clock (12 MHz); must be >= 20x SCL rate.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  raw I2C clock pin.
- sda_in  input  1  raw I2C data pin (read side).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- values  output  8*NUM_REGS  duty registers; reg i occupies bits [8i+7:8i].
- wr_strobe  output  1  one-clk pulse when a register is written.
- wr_index  output  log2(NUM_REGS)  index of the written register, valid with wr_strobe.
- busy  output  1  high from an addressed START until STOP.

Behaviour:
- Reset (async, rst=1):
  - all registers = 8'h00, sda_oe=0, wr_strobe=0, busy=0, pointer=0, state=IDLE.
  - filters preset to 1 (bus idle).
- Input conditioning:
  - scl and sda each pass through a 2-FF synchronizer, then a FILTER_LEN glitch filter.
  - Pin-to-internal latency is 2+FILTER_LEN clk.
- Event detection on the filtered lines:
  - START: sda falls while scl=1.
  - STOP: sda rises while scl=1.
  - Data bits are sampled on the filtered scl rising edge.
  - sda_oe changes only on the clk after a filtered scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT.
  - START from any state -> ADDR with bit counter cleared; this covers repeated START.
  - STOP from any state -> IDLE; sda_oe=0 on the next clk; busy=0.
  - ADDR:
    - After 8 bits, if addr==I2C_ADDR and R/W=0 -> ADDR_ACK, sda_oe=1 for the 9th bit, then PTR.
    - If addr matches and R/W=1 -> ACK, then RDATA.
    - Mismatch -> IDLE without ACK; busy stays 0.
  - PTR:
    - 8 bits received; pointer = byte modulo NUM_REGS (low bits only).
    - Always ACKed, then WDATA.
  - WDATA:
    - On the 8th bit, register[pointer] <= byte and wr_strobe pulses one clk with wr_index=pointer.
    - ACK, pointer increments modulo NUM_REGS (7 -> 0), stay in WDATA.
  - RDATA:
    - Shifts out register[pointer] MSB first: sda_oe = ~bit, changed after each scl falling edge.
    - After 8 bits, releases SDA and samples the master ACK on the 9th scl rise.
    - ACK (0) -> pointer++ and next byte.
    - NACK (1) -> RACK_WAIT, which ignores everything until START or STOP.
- values update on the clk after the commit and hold between writes; PWM outputs never see partial bytes.
- A STOP or START before the 8th bit discards the partial byte with no write.
- rst asserted mid-transfer aborts immediately: sda is released and registers return to 0.

Optional Feature:
- Macro: I2C_READBACK_EN.
  - Defined: read transfers supported as described in RDATA.
  - Undefined: an address byte with R/W=1 is NACKed and the block returns to IDLE; RDATA and RACK_WAIT logic are omitted.

Test Plan:
- Reset, then observe values -> all 64 bits 0; sda_oe=0; busy=0.
- 100 kHz write [0x84 addr+W, 0x02, 0x28] then STOP -> ACK on all three bytes; values[23:16]=0x28; one wr_strobe with wr_index=2.
- Write pointer 0x07 then data 0xFF, 0x11 -> reg7=0xFF, reg0=0x11 (wrap); exactly two wr_strobe pulses.
- Address 0x86 (0x43+W) -> no ACK (SDA stays released), no register change, busy=0.
- Write pointer 0x05, repeated START, read 0x85, read 2 bytes ACK/NACK, STOP -> SDA shows reg5 then reg6; with I2C_READBACK_EN undefined -> 0x85 is NACKed.
- 1-clk glitch on scl mid-byte and a STOP after 4 data bits -> glitch ignored; partial byte discarded; no wr_strobe.
